// File: rtl/frog_key_input.sv
// Frog game key front end: synchronizes four active-low keys and emits one-cycle move pulses with lockout.
// Optional auto-repeat of a held key is built when FROG_KEY_REPEAT_EN is defined.
module frog_key_input #(
    parameter int LOCKOUT       = 4,
    parameter int REPEAT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic       enable,
    output logic       L,
    output logic       R,
    output logic       F,
    output logic       B,
    output logic       busy
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HELD     = 2'd2
    } key_state_t;

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] pressed;
    logic [3:0] pressed_d;
    logic [1:0] warm;
    logic       warm_done;
    key_state_t state [4];
    logic [3:0] armed;
    logic [3:0] press_ev;
    logic       allow;
    logic [3:0] win;
    logic [3:0] move;
    logic [3:0] move_next;
    logic [7:0] lock_cnt;

    assign pressed   = ~sync2;
    assign warm_done = (warm == 2'd2);
    assign busy      = (lock_cnt != 8'd0);
    assign allow     = enable && !busy;
    assign press_ev  = pressed & ~pressed_d & armed;

    assign L = move[3];
    assign R = move[2];
    assign F = move[1];
    assign B = move[0];

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        armed = '0;
        for (int i = 0; i < 4; i++) begin
            armed[i] = (state[i] == ARMED);
        end
    end

    // Fixed priority L > R > F > B; losers are disarmed by the state update below.
    always_comb begin
        win = '0;
        if (allow) begin
            if (press_ev[3])      win = 4'b1000;
            else if (press_ev[2]) win = 4'b0100;
            else if (press_ev[1]) win = 4'b0010;
            else if (press_ev[0]) win = 4'b0001;
        end
    end

`ifdef FROG_KEY_REPEAT_EN
    logic       rpt_active;
    logic [1:0] rpt_key;
    logic [7:0] rpt_cnt;
    logic [3:0] rpt_mask;
    logic [3:0] changed;
    logic       rpt_cancel;
    logic       rpt_fire;
    logic [1:0] win_idx;

    assign rpt_mask   = 4'b0001 << rpt_key;
    assign changed    = pressed ^ pressed_d;
    // Another key moving, or the owner letting go, ends the repeat run.
    assign rpt_cancel = (|(changed & ~rpt_mask)) || !pressed[rpt_key];
    assign rpt_fire   = rpt_active && !rpt_cancel && allow && (win == 4'b0000)
                        && (rpt_cnt >= 8'(REPEAT_CYCLES - 1));

    always_comb begin
        win_idx = 2'd0;
        if (win[3])      win_idx = 2'd3;
        else if (win[2]) win_idx = 2'd2;
        else if (win[1]) win_idx = 2'd1;
    end

    assign move_next = win | (rpt_fire ? rpt_mask : 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_active <= 1'b0;
            rpt_key    <= 2'd0;
            rpt_cnt    <= 8'd0;
        end else if (win != 4'b0000) begin
            rpt_active <= 1'b1;
            rpt_key    <= win_idx;
            rpt_cnt    <= 8'd0;
        end else if (rpt_active && rpt_cancel) begin
            rpt_active <= 1'b0;
            rpt_cnt    <= 8'd0;
        end else if (rpt_fire) begin
            rpt_cnt <= 8'd0;
        end else if (rpt_active && rpt_cnt != 8'hFF) begin
            rpt_cnt <= rpt_cnt + 8'd1;
        end
    end
`else
    assign move_next = win;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 4'hF;
            sync2     <= 4'hF;
            pressed_d <= 4'h0;
            warm      <= 2'd0;
            move      <= 4'h0;
            lock_cnt  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= DISARMED;
            end
        end else begin
            sync1     <= KEY;
            sync2     <= sync1;
            pressed_d <= pressed;
            move      <= move_next;
            if (!warm_done) begin
                warm <= warm + 2'd1;
            end

            if (move_next != 4'h0) begin
                lock_cnt <= 8'(LOCKOUT);
            end else if (lock_cnt != 8'd0) begin
                lock_cnt <= lock_cnt - 8'd1;
            end

            // Arming waits until the synchronizer holds real samples, so a key held through reset stays disarmed.
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    DISARMED: if (warm_done && !pressed[i]) state[i] <= ARMED;
                    ARMED:    if (press_ev[i])              state[i] <= HELD;
                    HELD:     if (!pressed[i])              state[i] <= ARMED;
                    default:                                state[i] <= DISARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_key_input.sv
// Scoreboard bench for frog_key_input: stimulus queues expected pulses, a negedge monitor compares them.
module tb_frog_key_input;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic       enable;
    logic       L, R, F, B, busy;

    typedef struct {
        logic [3:0] dir;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    frog_key_input #(.LOCKOUT(4), .REPEAT_CYCLES(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .KEY    (KEY),
        .enable (enable),
        .L      (L),
        .R      (R),
        .F      (F),
        .B      (B),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [3:0] dir, input int at);
        exp_t e;
        e.dir = dir;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed move pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] mv;
        exp_t       e;
        mv = {L, R, F, B};
        if (mv !== 4'b0000 && mv !== 4'bxxxx) begin
            check("pulse_onehot", 32'($countones(mv)), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, mv}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_dir", {28'd0, mv}, {28'd0, e.dir});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset  = 1'b1;
        KEY    = 4'b1111;
        enable = 1'b1;
        tick(2);
        check("reset_L", {31'd0, L}, 32'd0);
        check("reset_R", {31'd0, R}, 32'd0);
        check("reset_F", {31'd0, F}, 32'd0);
        check("reset_B", {31'd0, B}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(4);

        // Single left press: pulse 3 edges after the fall, busy for 4 cycles.
        c = cyc;
        KEY = 4'b0111;
        expect_pulse(4'b1000, c + 3);
        tick(3);
        for (int k = 0; k < 4; k++) begin
            check("busy_high", {31'd0, busy}, 32'd1);
            tick(1);
        end
        check("busy_low_after_lockout", {31'd0, busy}, 32'd0);
        tick(3);
        KEY = 4'b1111;
        tick(6);

        // Simultaneous L and F: only L; F then needs release and fresh press.
        c = cyc;
        KEY = 4'b0101;
        expect_pulse(4'b1000, c + 3);
        tick(8);
        KEY = 4'b1111;
        tick(4);
        c = cyc;
        KEY = 4'b1101;
        expect_pulse(4'b0010, c + 3);
        tick(6);
        KEY = 4'b1111;
        tick(6);

        // Right, quick re-press lands in lockout and is dropped, later press works.
        c = cyc;
        KEY = 4'b1011;
        expect_pulse(4'b0100, c + 3);
        tick(1);
        KEY = 4'b1111;
        tick(1);
        KEY = 4'b1011;
        tick(2);
        check("busy_during_repress", {31'd0, busy}, 32'd1);
        tick(6);
        KEY = 4'b1111;
        tick(6);
        check("busy_idle", {31'd0, busy}, 32'd0);
        c = cyc;
        KEY = 4'b1011;
        expect_pulse(4'b0100, c + 3);
        tick(5);
        KEY = 4'b1111;
        tick(6);

        // Press while disabled, enable rises with key held: no B until re-press.
        enable = 1'b0;
        KEY = 4'b1110;
        tick(5);
        enable = 1'b1;
        tick(6);
        KEY = 4'b1111;
        tick(4);
        c = cyc;
        KEY = 4'b1110;
        expect_pulse(4'b0001, c + 3);
        tick(5);
        KEY = 4'b1111;
        tick(6);

        // Forward held through reset stays silent until released and pressed again.
        KEY = 4'b1101;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        KEY = 4'b1111;
        tick(4);
        c = cyc;
        KEY = 4'b1101;
        expect_pulse(4'b0010, c + 3);
        tick(5);
        KEY = 4'b1111;
        tick(6);

        // Reset during lockout clears busy and pulse; held key does not fire afterwards.
        c = cyc;
        KEY = 4'b0111;
        expect_pulse(4'b1000, c + 3);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("midreset_L", {31'd0, L}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(6);
        KEY = 4'b1111;
        tick(6);

        // Long left hold: repeat every 16 cycles when built with repeat, else one pulse.
        c = cyc;
        KEY = 4'b0111;
        expect_pulse(4'b1000, c + 3);
`ifdef FROG_KEY_REPEAT_EN
        expect_pulse(4'b1000, c + 19);
        expect_pulse(4'b1000, c + 35);
`endif
        tick(40);
        KEY = 4'b1111;
        tick(10);

        check("all_expected_pulses_seen", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_key_input.md
FROG_KEY_INPUT -- requirements
Module: frog_key_input

Interface
REQ-001 SHALL have parameter LOCKOUT, default 4, meaning cycles after any move pulse during which new presses are discarded (range 1..255).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 16, meaning auto-repeat period in cycles (range 2..255; used only per REQ-025).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 KEY  input  4  raw asynchronous board keys, active-low; KEY[3]=left, KEY[2]=right, KEY[1]=forward, KEY[0]=backward.
REQ-006 enable  input  1  high while play is allowed; low suppresses all moves.
REQ-007 L  output  1  one-cycle left-move pulse to the frog light array.
REQ-008 R  output  1  one-cycle right-move pulse.
REQ-009 F  output  1  one-cycle forward-move pulse.
REQ-010 B  output  1  one-cycle backward-move pulse.
REQ-011 busy  output  1  high while the lockout counter is nonzero.

Function
REQ-012 Each KEY bit SHALL pass through a two-flop synchronizer, then be inverted to a pressed level P[i].
REQ-013 A press event on key i SHALL be P[i] rising (0 then 1 on consecutive cycles) while key i is armed.
REQ-014 Key i SHALL be armed only after P[i]=0 has been seen since reset or since its last consumed or discarded press.
REQ-015 Latency: KEY[i] low and stable before edge n -> move pulse high for exactly the cycle following edge n+2.
REQ-016 At most one of L, R, F, B SHALL be high in any cycle (one-hot or all zero).
REQ-017 Simultaneous press events SHALL resolve by priority L > R > F > B; losing keys are disarmed without pulsing.
REQ-018 A pulse SHALL load the lockout counter with LOCKOUT; the counter decrements each cycle to 0; busy = (counter != 0).
REQ-019 Press events occurring while busy=1 SHALL be discarded and the key disarmed (no queuing).
REQ-020 Press events occurring while enable=0 SHALL be discarded and the key disarmed; a key held when enable rises SHALL NOT pulse.
REQ-021 Per-key state machine: DISARMED -(P=0)-> ARMED -(press event)-> HELD -(P=0)-> ARMED; discard or lose arbitration -> HELD.
REQ-022 The lockout counter SHALL saturate at 0 and never wrap.

Reset
REQ-023 On reset: synchronizer flops = released (1), all keys DISARMED, lockout counter 0, L=R=F=B=0, busy=0, repeat counters 0.
REQ-024 Reset asserted mid-press or mid-lockout SHALL take effect at the next edge; a key held through reset deassertion SHALL NOT pulse until released and pressed again.

Configuration
REQ-025 With FROG_KEY_REPEAT_EN defined: a key in HELD whose press produced a pulse, still pressed, with enable=1 and busy=0, SHALL re-pulse every REPEAT_CYCLES cycles after its previous pulse; any other key pressing or releasing cancels repeat.
REQ-026 With FROG_KEY_REPEAT_EN undefined: a held key SHALL produce exactly one pulse per press; no repeat counter logic SHALL be present.

Verification
REQ-027 reset 1 cycle, enable=1, KEY=4'b0111 held 10 cycles -> L=1 exactly once, at 3rd edge after KEY fall; busy high for 4 cycles after pulse; R=F=B=0.
REQ-028 KEY goes 4'b1111 -> 4'b0101 in one cycle -> only L pulses; after KEY=4'b1111 then 4'b1101 -> F pulses once.
REQ-029 KEY[2] pulse -> R; second KEY[2] press 2 cycles after R pulse (busy=1) -> no pulse; release and press after busy=0 -> R pulses.
REQ-030 enable=0, press KEY[0], raise enable while held -> no B; release and re-press -> B pulses once.
REQ-031 KEY[1] held low through reset and 5 cycles after -> no F; release, press -> F pulses once.
REQ-032 FROG_KEY_REPEAT_EN defined, KEY[3] held 40 cycles -> L pulses at t0, t0+16, t0+32; undefined -> single L pulse.
